// File: rtl/sys_defs.sv
// Shared types for the data-cache miss/writeback path: bus commands, MSHR and writeback entries.
// Pure declarations; no timing or flow control of its own.
package sys_defs;

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } BUS_COMMAND;

    localparam int DCACHE_IDX_W = 5;
    localparam int DCACHE_TAG_W = 8;

    typedef enum logic [1:0] {
        INVALID    = 2'h0,
        WAIT_ISSUE = 2'h1,
        WAIT_MEM   = 2'h2,
        DONE       = 2'h3
    } MSHR_STATE;

    typedef struct packed {
        MSHR_STATE   state;
        logic [15:0] addr;
        logic [3:0]  mem_tag;
        logic [63:0] data;
    } MSHR_ENTRY;

    typedef struct packed {
        logic [15:0] addr;
        logic [63:0] data;
    } WB_ENTRY;

    function automatic logic [15:0] blk_addr(input logic [15:0] a);
        return {a[15:3], 3'b000};
    endfunction

endpackage

// File: rtl/dcache_wb_fifo.sv
// Dirty-victim FIFO: 3-wide push (port 2 first), 1 pop, visible to pop the cycle after push.
// Never stalls pushes; almost_full warns upstream while fewer than 3 slots are free.
module dcache_wb_fifo
    import sys_defs::*;
#(
    parameter int DEPTH = 4,
    parameter int NCMP  = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [2:0]            push,
    input  WB_ENTRY [2:0]         push_entry,
    input  logic                  pop,
    output WB_ENTRY               head,
    output logic                  empty,
    output logic                  almost_full,
    input  logic [NCMP-1:0][15:0] cmp_addr,
    output logic [NCMP-1:0]       cmp_hit
);

    WB_ENTRY          mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [1:0]       off [3];
    logic [2:0]       n_push;
    logic             do_pop;
    logic [DEPTH-1:0] slot_vld;

    // Sum never exceeds 2*DEPTH, so a single conditional subtract wraps it.
    function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input logic [1:0] o);
        logic [PTR_W:0] s;
        s = {1'b0, p} + (PTR_W+1)'(o);
        if (s >= (PTR_W+1)'(DEPTH))
            s = s - (PTR_W+1)'(DEPTH);
        return s[PTR_W-1:0];
    endfunction

    always_comb begin
        off[2] = 2'd0;
        off[1] = {1'b0, push[2]};
        off[0] = {1'b0, push[2]} + {1'b0, push[1]};
        n_push = {1'b0, off[0]} + {2'b00, push[0]};
    end

    assign empty       = (count == '0);
    assign do_pop      = pop && !empty;
    assign head        = mem[rd_ptr];
    assign almost_full = (DEPTH - int'(count)) < 3;

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_pop)
                rd_ptr <= ptr_add(rd_ptr, 2'd1);
            wr_ptr <= ptr_add(wr_ptr, n_push[1:0]);
            count  <= count + CNT_W'(n_push) - CNT_W'(do_pop);
        end
    end

    // When full, a same-cycle pop frees the head slot that wr_ptr points at.
    always_ff @(posedge clock) begin
        for (int k = 0; k < 3; k++) begin
            if (push[k])
                mem[ptr_add(wr_ptr, off[k])] <= push_entry[k];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset)
            assert (int'(count) + int'(n_push) - int'(do_pop) <= DEPTH);
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            slot_vld[i] = ((i >= int'(rd_ptr)) ? (i - int'(rd_ptr))
                                               : (i + DEPTH - int'(rd_ptr))) < int'(count);
        end
    end

    // Same-cycle pushes count as hits so a load never overtakes a writeback.
    always_comb begin
        for (int c = 0; c < NCMP; c++) begin
            cmp_hit[c] = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                if (slot_vld[i] && (mem[i].addr == cmp_addr[c]))
                    cmp_hit[c] = 1'b1;
            end
            for (int k = 0; k < 3; k++) begin
                if (push[k] && (push_entry[k].addr == cmp_addr[c]))
                    cmp_hit[c] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Data-cache miss/writeback controller: MSHR table, writeback FIFO, single-command Dmem issue, fill port.
// Miss -> BUS_LOAD one cycle later, data tag -> wr2 one cycle later; misses stall only when no MSHR is free.
module dcache_ctrl
    import sys_defs::*;
#(
    parameter int MSHR_NUM = 4,
    parameter int WB_DEPTH = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [2:0]              evict_valid,
    input  logic [2:0][15:0]        evict_addr,
    input  logic [2:0][63:0]        evict_data,
    output logic                    wb_almost_full,
    input  logic [1:0]              miss_valid,
    input  logic [1:0][15:0]        miss_addr,
    output logic [1:0]              miss_stall,
    output logic                    wr2_en,
    output logic [DCACHE_IDX_W-1:0] wr2_idx,
    output logic [DCACHE_TAG_W-1:0] wr2_tag,
    output logic [63:0]             wr2_data,
    output logic [1:0]              proc2Dmem_command,
    output logic [31:0]             proc2Dmem_addr,
    output logic [63:0]             proc2Dmem_data,
    input  logic [3:0]              Dmem2proc_response,
    input  logic [63:0]             Dmem2proc_data,
    input  logic [3:0]              Dmem2proc_tag
);

    localparam int MI_W = (MSHR_NUM > 1) ? $clog2(MSHR_NUM) : 1;

    MSHR_ENTRY                mshr [MSHR_NUM];
    WB_ENTRY [2:0]            wb_push_entry;
    WB_ENTRY                  wb_head;
    logic                     wb_empty;
    logic                     wb_pop;
    logic [MSHR_NUM-1:0][15:0] cmp_addr;
    logic [MSHR_NUM-1:0]      cmp_hit;

    logic [15:0]     blk1, blk0;
    logic            hit1, hit0, same_blk, need1, need0;
    logic            got1, got0, stall1;
    logic [MI_W-1:0] free1, free0;
    logic            issue_load, load_acc;
    logic [MI_W-1:0] issue_sel;
    logic            fill_vld;
    logic [MI_W-1:0] fill_sel;

    always_comb begin
        for (int k = 0; k < 3; k++)
            wb_push_entry[k] = '{addr: evict_addr[k], data: evict_data[k]};
        for (int i = 0; i < MSHR_NUM; i++)
            cmp_addr[i] = mshr[i].addr;
    end

    dcache_wb_fifo #(
        .DEPTH (WB_DEPTH),
        .NCMP  (MSHR_NUM)
    ) u_wb_fifo (
        .clock       (clock),
        .reset       (reset),
        .push        (evict_valid),
        .push_entry  (wb_push_entry),
        .pop         (wb_pop),
        .head        (wb_head),
        .empty       (wb_empty),
        .almost_full (wb_almost_full),
        .cmp_addr    (cmp_addr),
        .cmp_hit     (cmp_hit)
    );

    // Port 1 allocates first; port 0 merges with port 1 or any live entry of the same block.
    always_comb begin
        blk1     = blk_addr(miss_addr[1]);
        blk0     = blk_addr(miss_addr[0]);
        hit1     = 1'b0;
        hit0     = 1'b0;
        for (int i = 0; i < MSHR_NUM; i++) begin
            if (mshr[i].state != INVALID) begin
                if (mshr[i].addr == blk1) hit1 = 1'b1;
                if (mshr[i].addr == blk0) hit0 = 1'b1;
            end
        end
        same_blk = miss_valid[1] && (blk0 == blk1);
        need1    = miss_valid[1] && !hit1;
        need0    = miss_valid[0] && !hit0 && !same_blk;
        got1     = 1'b0;
        got0     = 1'b0;
        free1    = '0;
        free0    = '0;
        for (int i = 0; i < MSHR_NUM; i++) begin
            if (mshr[i].state == INVALID) begin
                if (need1 && !got1) begin
                    got1  = 1'b1;
                    free1 = MI_W'(i);
                end else if (need0 && !got0) begin
                    got0  = 1'b1;
                    free0 = MI_W'(i);
                end
            end
        end
        stall1        = need1 && !got1;
        miss_stall[1] = stall1;
        miss_stall[0] = same_blk ? (miss_valid[0] && stall1) : (need0 && !got0);
    end

    // Writebacks always win the bus; a load waits while its block is still queued for writeback.
    always_comb begin
        issue_load = 1'b0;
        issue_sel  = '0;
        for (int i = 0; i < MSHR_NUM; i++) begin
            if (!issue_load && (mshr[i].state == WAIT_ISSUE) && !cmp_hit[i]) begin
                issue_load = 1'b1;
                issue_sel  = MI_W'(i);
            end
        end
        proc2Dmem_command = BUS_NONE;
        proc2Dmem_addr    = 32'h0;
        proc2Dmem_data    = 64'h0;
        if (!wb_empty) begin
            proc2Dmem_command = BUS_STORE;
            proc2Dmem_addr    = {16'h0, wb_head.addr};
            proc2Dmem_data    = wb_head.data;
        end else if (issue_load) begin
            proc2Dmem_command = BUS_LOAD;
            proc2Dmem_addr    = {16'h0, mshr[issue_sel].addr};
        end
        wb_pop   = !wb_empty && (Dmem2proc_response != 4'h0);
        load_acc = wb_empty && issue_load && (Dmem2proc_response != 4'h0);
    end

    always_comb begin
        fill_vld = 1'b0;
        fill_sel = '0;
        for (int i = 0; i < MSHR_NUM; i++) begin
            if (!fill_vld && (mshr[i].state == DONE)) begin
                fill_vld = 1'b1;
                fill_sel = MI_W'(i);
            end
        end
        wr2_en   = fill_vld;
        wr2_idx  = '0;
        wr2_tag  = '0;
        wr2_data = 64'h0;
        if (fill_vld) begin
            wr2_idx  = mshr[fill_sel].addr[7:3];
            wr2_tag  = mshr[fill_sel].addr[15:8];
            wr2_data = mshr[fill_sel].data;
        end
    end

    // Tag return, issue acceptance, fill and allocation always touch distinct entries.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < MSHR_NUM; i++)
                mshr[i] <= '0;
        end else begin
            for (int i = 0; i < MSHR_NUM; i++) begin
                if ((mshr[i].state == WAIT_MEM) && (Dmem2proc_tag != 4'h0)
                        && (Dmem2proc_tag == mshr[i].mem_tag)) begin
                    mshr[i].state <= DONE;
                    mshr[i].data  <= Dmem2proc_data;
                end
            end
            if (load_acc) begin
                mshr[issue_sel].state   <= WAIT_MEM;
                mshr[issue_sel].mem_tag <= Dmem2proc_response;
            end
            if (fill_vld)
                mshr[fill_sel].state <= INVALID;
            if (got1)
                mshr[free1] <= '{state: WAIT_ISSUE, addr: blk1, mem_tag: 4'h0, data: 64'h0};
            if (got0)
                mshr[free0] <= '{state: WAIT_ISSUE, addr: blk0, mem_tag: 4'h0, data: 64'h0};
        end
    end

endmodule

// File: doc/dcache_ctrl.md
# dcache_ctrl

Miss and writeback controller for the data cache: the memory-side counterpart of the dcache storage array. Accepts load-miss requests and dirty-victim evictions from the dcache/LSQ side, issues them one per cycle to the data memory bus, tracks outstanding loads in an MSHR table, and returns each filled block to the array through the miss-fill write port (`wr2_*`). The block sits between the dcache and the `Dmem` bus arbiter.

## Interface
Parameters:
- `MSHR_NUM`, 4: outstanding load-miss entries.
- `WB_DEPTH`, 4: writeback FIFO entries; must be at least 3.

Ports:
- `clock`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `evict_valid`  in  3  per store port; equals the array's `need_write_mem`.
- `evict_addr`  in  3x16  victim block address `{old_tag[7:0], idx[4:0], 3'b0}`.
- `evict_data`  in  3x64  victim data; equals the array's `wb_mem_data`.
- `wb_almost_full`  out  1  free FIFO slots < 3; the LSQ holds store retirement while this is high.
- `miss_valid`  in  2  per load port: load missed.
- `miss_addr`  in  2x16  missed address; low 3 bits are ignored.
- `miss_stall`  out  2  request not accepted this cycle; the port retries.
- `wr2_en`  out  1  fill write to the array.
- `wr2_idx`  out  5  fill index.
- `wr2_tag`  out  8  fill tag.
- `wr2_data`  out  64  fill data.
- `proc2Dmem_command`  out  2  `BUS_NONE` / `BUS_LOAD` / `BUS_STORE`.
- `proc2Dmem_addr`  out  32  zero-extended 16-bit block address.
- `proc2Dmem_data`  out  64  store data.
- `Dmem2proc_response`  in  4  nonzero transaction tag means accepted; 0 means rejected.
- `Dmem2proc_data`  in  64  load return data.
- `Dmem2proc_tag`  in  4  nonzero when load data returns with this tag.

## Operation
- **Writeback FIFO.** Each cycle, enqueue all asserted `evict_valid` entries in order port 2, 1, 0. Head is issued as `BUS_STORE`. Pop when `Dmem2proc_response != 0` while the head is driven. Enqueue beyond capacity is an assertion failure.
- **MSHR entry states:**
  - `INVALID` -> `WAIT_ISSUE`: request allocated.
  - `WAIT_ISSUE` -> `WAIT_MEM`: load accepted; latch `Dmem2proc_response` as the entry's mem tag.
  - `WAIT_MEM` -> `DONE`: `Dmem2proc_tag` equals the mem tag; latch the data.
  - `DONE` -> `INVALID`: entry drives `wr2`.
- **Miss allocation.** Port 1 has priority over port 0, and each port uses the lowest-index free entry.
  - If the block address matches a valid entry, or the other port in the same cycle, the requests merge: no new entry and no stall.
  - A miss is stalled only when no free entry remains.
- **Bus issue.** At most one command per cycle, combinational from registered state.
  - A non-empty writeback FIFO has priority.
  - Otherwise issue the lowest-index `WAIT_ISSUE` entry whose block address matches no FIFO entry, including entries enqueued this cycle. This is a RAW hazard against in-flight writebacks.
  - If nothing qualifies, drive `BUS_NONE` with addr/data 0.
- **Rejected commands** (response 0) are retried the next cycle with state unchanged.
- **Fill.** Each cycle, the lowest-index `DONE` entry drives `wr2_en=1`, `wr2_idx=addr[7:3]`, `wr2_tag=addr[15:8]`, `wr2_data`. At most one fill per cycle; remaining `DONE` entries wait.
- **Fill/store overlap.** A fill and a same-index store in one cycle are resolved by the array: the store bytes win. The controller takes no action.

## Timing
- **Reset:** FIFO empty, all MSHRs `INVALID`, `wr2_*`=0, `miss_stall`=0, `wb_almost_full`=0, command `BUS_NONE`, addr/data 0.
- **Reset mid-operation** drops all pending work. Later `Dmem2proc_tag` returns match no entry and are ignored.
- **Miss latency:**
  - Miss at cycle N -> `BUS_LOAD` no earlier than N+1.
  - Data tag at cycle M -> `wr2_en` at M+1.
- **Eviction:** enqueued at N -> `BUS_STORE` no earlier than N+1.
- **`miss_stall`** is combinational from the current MSHR occupancy and this cycle's requests.
- **Entry reuse:** an entry freed by a fill at cycle N is allocatable at N+1.
- **Same-cycle tag return and issue acceptance** both update state; the two entries differ.
- **FIFO wrap:** pointers are `$clog2(WB_DEPTH)` bits with an explicit count.
- **Full FIFO:** pop and push in the same cycle are both honored.

## Structure
- Shared package `sys_defs`:
  - `BUS_COMMAND` enum.
  - `DCACHE_IDX_W=5`, `DCACHE_TAG_W=8`.
  - `MSHR_STATE` enum.
  - `MSHR_ENTRY` struct: state, addr[15:0], mem_tag[3:0], data[63:0].
  - `WB_ENTRY` struct: addr, data.
- Sub-module `dcache_wb_fifo`: 3-wide push, 1 pop, count, almost-full flag, and a full-content address compare port for the RAW check.

## Test plan
- **Single miss:** miss_addr[0]=0x1238 -> `BUS_LOAD` addr 0x1238 next cycle. Response 3, then tag 3 with data 0xDEAD -> `wr2_en` with idx 0x07, tag 0x12, data 0xDEAD one cycle later.
- **Merge:** both ports miss 0x0A40 and 0x0A44 in one cycle -> one MSHR, one `BUS_LOAD`, no stall.
- **RAW ordering:** evict 0x2200 plus miss 0x2200 in the same cycle -> `BUS_STORE` 0x2200 accepted before any `BUS_LOAD` 0x2200.
- **Rejection:** response 0 for 3 cycles -> the same command is held for 3 cycles, then proceeds on a nonzero response.
- **Full MSHR:** 4 distinct outstanding misses plus a fifth -> `miss_stall` asserted until the first fill, then accepted the cycle after.
- **Reset mid-flight:** reset with 2 loads outstanding -> a returning tag produces no `wr2_en`, and all outputs hold their reset values.
